// File: rtl/ctrl_pipe_chain_if.sv
// Bundle of decode-side inputs, stage controls and per-stage observation outputs
// for the back-end control-word pipeline.
interface ctrl_pipe_chain_if #(
  parameter int WIDTH  = 11,
  parameter int STAGES = 3,
  parameter int REGW   = 5,
  parameter int CNTW   = 16
);
  logic                      in_valid;
  logic [WIDTH-1:0]          in_ctrl;
  logic                      in_wr;
  logic [REGW-1:0]           in_dst;
  logic [STAGES-1:0]         stall;
  logic [STAGES-1:0]         flush;
  logic [REGW-1:0]           rs;
  logic [REGW-1:0]           rt;
  logic [STAGES*WIDTH-1:0]   ctrl_out;
  logic [STAGES-1:0]         valid_out;
  logic [STAGES-1:0]         wr_out;
  logic [STAGES*REGW-1:0]    dst_out;
  logic [STAGES-1:0]         hit_rs;
  logic [STAGES-1:0]         hit_rt;
  logic                      hold_out;
  logic [CNTW-1:0]           bubble_cnt;

  modport master (
    output in_valid, in_ctrl, in_wr, in_dst, stall, flush, rs, rt,
    input  ctrl_out, valid_out, wr_out, dst_out, hit_rs, hit_rt, hold_out, bubble_cnt
  );

  modport slave (
    input  in_valid, in_ctrl, in_wr, in_dst, stall, flush, rs, rt,
    output ctrl_out, valid_out, wr_out, dst_out, hit_rs, hit_rt, hold_out, bubble_cnt
  );
endinterface

// File: rtl/ctrl_pipe_chain.sv
// Parametrised chain of control-word stages with per-stage stall/flush,
// destination hazard matching and a saturating last-stage bubble counter.
module ctrl_pipe_chain #(
  parameter int WIDTH  = 11,
  parameter int STAGES = 3,
  parameter int REGW   = 5,
  parameter int CNTW   = 16
) (
  input logic          clk,
  input logic          rst,
  ctrl_pipe_chain_if.slave bus
);

  logic [STAGES-1:0]             hold, up_hold;
  logic [STAGES-1:0]             valid_q, valid_d, src_valid;
  logic [STAGES-1:0]             wr_q, wr_d, src_wr;
  logic [STAGES-1:0][WIDTH-1:0]  ctrl_q, ctrl_d, src_ctrl;
  logic [STAGES-1:0][REGW-1:0]   dst_q, dst_d, src_dst;
  logic [STAGES-1:0]             hit_rs, hit_rt;
  logic [CNTW-1:0]               bubble_q;

  // A stall anywhere downstream freezes this stage too, so nothing in flight is overwritten.
  always_comb begin
    hold = '0;
    for (int k = 0; k < STAGES; k++) hold[k] = |(bus.stall >> k);
  end

  always_comb begin
    src_valid = '0;
    src_wr    = '0;
    src_ctrl  = '0;
    src_dst   = '0;
    up_hold   = '0;
    src_valid[0] = bus.in_valid;
    src_ctrl[0]  = bus.in_ctrl;
    src_wr[0]    = bus.in_wr & bus.in_valid;
    src_dst[0]   = bus.in_dst;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_ctrl[k]  = ctrl_q[k-1];
      src_wr[k]    = wr_q[k-1];
      src_dst[k]   = dst_q[k-1];
      up_hold[k]   = hold[k-1];
    end
  end

  // Priority per stage: flush, hold, bubble behind a frozen upstream stage, advance.
  always_comb begin
    valid_d = valid_q;
    wr_d    = wr_q;
    ctrl_d  = ctrl_q;
    dst_d   = dst_q;
    for (int k = 0; k < STAGES; k++) begin
      if (bus.flush[k] || (!hold[k] && up_hold[k])) begin
        valid_d[k] = 1'b0;
        wr_d[k]    = 1'b0;
        ctrl_d[k]  = '0;
        dst_d[k]   = '0;
      end else if (!hold[k]) begin
        valid_d[k] = src_valid[k];
        wr_d[k]    = src_wr[k];
        ctrl_d[k]  = src_ctrl[k];
        dst_d[k]   = src_dst[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      wr_q     <= '0;
      ctrl_q   <= '0;
      dst_q    <= '0;
      bubble_q <= '0;
    end else begin
      valid_q <= valid_d;
      wr_q    <= wr_d;
      ctrl_q  <= ctrl_d;
      dst_q   <= dst_d;
      if (!valid_q[STAGES-1] && (bubble_q != {CNTW{1'b1}}))
        bubble_q <= bubble_q + CNTW'(1);
    end
  end

  // Register 0 is hardwired, so it never forms a hazard.
  always_comb begin
    hit_rs = '0;
    hit_rt = '0;
    for (int k = 0; k < STAGES; k++) begin
      hit_rs[k] = valid_q[k] & wr_q[k] & (dst_q[k] == bus.rs) & (bus.rs != '0);
      hit_rt[k] = valid_q[k] & wr_q[k] & (dst_q[k] == bus.rt) & (bus.rt != '0);
    end
  end

  assign bus.ctrl_out   = ctrl_q;
  assign bus.valid_out  = valid_q;
  assign bus.wr_out     = wr_q & valid_q;
  assign bus.dst_out    = dst_q;
  assign bus.hit_rs     = hit_rs;
  assign bus.hit_rt     = hit_rt;
  assign bus.hold_out   = hold[0];
  assign bus.bubble_cnt = bubble_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Self-checking bench for ctrl_pipe_chain: directed scenarios plus randomized
// traffic compared against a stage-list reference model.
module tb_ctrl_pipe_chain;
  localparam int W = 11;
  localparam int S = 3;
  localparam int R = 5;
  localparam int C = 4;
  localparam int CMAX = (1 << C) - 1;

  typedef struct packed {
    logic         v;
    logic [W-1:0] c;
    logic         w;
    logic [R-1:0] d;
  } stage_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;

  stage_t m [S];
  int     m_cnt = 0;

  ctrl_pipe_chain_if #(.WIDTH(W), .STAGES(S), .REGW(R), .CNTW(C)) bus ();

  ctrl_pipe_chain #(.WIDTH(W), .STAGES(S), .REGW(R), .CNTW(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: each stage is a record; the rules are applied straight from the description.
  task automatic model_edge();
    stage_t nx [S];
    for (int k = 0; k < S; k++) begin
      logic held, up_frozen;
      int   up;
      held = 1'b0;
      up_frozen = 1'b0;
      up = (k > 0) ? k - 1 : 0;
      for (int j = k; j < S; j++) if (bus.stall[j]) held = 1'b1;
      if (k > 0) for (int j = k - 1; j < S; j++) if (bus.stall[j]) up_frozen = 1'b1;
      if (rst || bus.flush[k]) nx[k] = '0;
      else if (held) nx[k] = m[k];
      else if (up_frozen) nx[k] = '0;
      else if (k == 0) nx[k] = {bus.in_valid, bus.in_ctrl, bus.in_wr & bus.in_valid, bus.in_dst};
      else nx[k] = m[up];
    end
    if (rst) m_cnt = 0;
    else if (!m[S-1].v && m_cnt < CMAX) m_cnt++;
    for (int k = 0; k < S; k++) m[k] = nx[k];
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic present(input logic v, input logic [W-1:0] c, input logic w, input logic [R-1:0] d);
    bus.in_valid = v;
    bus.in_ctrl  = c;
    bus.in_wr    = w;
    bus.in_dst   = d;
  endtask

  function automatic logic [W-1:0] ctrl_at(input int k);
    return bus.ctrl_out[k*W +: W];
  endfunction

  function automatic logic [R-1:0] dst_at(input int k);
    return bus.dst_out[k*R +: R];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.stall = '0;
    bus.flush = '0;
    bus.rs = 5'd9;
    bus.rt = 5'd9;
    present(1'b1, 11'h2AA, 1'b1, 5'd9);
    step();
    n_checks++;
    if (bus.valid_out !== 3'b000 || bus.ctrl_out !== '0 || bus.dst_out !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: valid=%b ctrl=%h dst=%h, expected all 0", bus.valid_out, bus.ctrl_out, bus.dst_out);
    end
    n_checks++;
    if (bus.wr_out !== 3'b000 || bus.hit_rs !== 3'b000 || bus.hit_rt !== 3'b000 ||
        bus.hold_out !== 1'b0 || bus.bubble_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_outs: wr=%b hit_rs=%b hit_rt=%b hold=%b cnt=%0d, expected all 0",
               bus.wr_out, bus.hit_rs, bus.hit_rt, bus.hold_out, bus.bubble_cnt);
    end
    step();
    rst = 1'b0;
    present(1'b1, 11'h155, 1'b1, 5'd7);
    for (int i = 0; i < S; i++) begin
      logic [S-1:0] exp_v;
      exp_v = S'((1 << (i + 1)) - 1);
      step();
      n_checks++;
      if (bus.valid_out !== exp_v) begin
        n_fail++;
        $display("FAIL fill_valid step %0d: got %b expected %b", i, bus.valid_out, exp_v);
      end
    end
    n_checks++;
    if (ctrl_at(2) !== 11'h155 || dst_at(2) !== 5'd7 || bus.wr_out !== 3'b111) begin
      n_fail++;
      $display("FAIL fill_stage2: ctrl=%h dst=%0d wr=%b expected 155 7 111", ctrl_at(2), dst_at(2), bus.wr_out);
    end
  endtask

  task automatic test_mid_stall();
    logic [W-1:0] seq [4];
    seq[0] = 11'h0A1; seq[1] = 11'h0B2; seq[2] = 11'h0C3; seq[3] = 11'h0D4;
    for (int i = 0; i < 3; i++) begin
      present(1'b1, seq[i], 1'b1, R'(i + 1));
      step();
    end
    n_checks++;
    if (ctrl_at(1) !== seq[1] || ctrl_at(0) !== seq[2]) begin
      n_fail++;
      $display("FAIL stall_setup: s0=%h s1=%h expected %h %h", ctrl_at(0), ctrl_at(1), seq[2], seq[1]);
    end
    bus.stall = 3'b010;
    present(1'b1, seq[3], 1'b1, 5'd4);
    #1;
    n_checks++;
    if (bus.hold_out !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_hold_out: got %b expected 1", bus.hold_out);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (ctrl_at(0) !== seq[2] || ctrl_at(1) !== seq[1] || bus.valid_out[2] !== 1'b0 || ctrl_at(2) !== '0) begin
        n_fail++;
        $display("FAIL stall_cycle %0d: s0=%h s1=%h s2v=%b s2=%h expected %h %h 0 0",
                 i, ctrl_at(0), ctrl_at(1), bus.valid_out[2], ctrl_at(2), seq[2], seq[1]);
      end
    end
    bus.stall = '0;
    for (int i = 1; i < 4; i++) begin
      step();
      if (i == 1) present(1'b0, '0, 1'b0, '0);
      n_checks++;
      if (ctrl_at(2) !== seq[i] || bus.valid_out[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_resume %0d: s2=%h v=%b expected %h 1", i, ctrl_at(2), bus.valid_out[2], seq[i]);
      end
    end
  endtask

  task automatic test_flush_vs_stall();
    present(1'b1, 11'h111, 1'b1, 5'd8);  step();
    present(1'b1, 11'h222, 1'b1, 5'd9);  step();
    present(1'b1, 11'h333, 1'b1, 5'd5);  step();
    bus.rs = 5'd5;
    bus.rt = 5'd0;
    #1;
    n_checks++;
    if (bus.hit_rs !== 3'b001) begin
      n_fail++;
      $display("FAIL flush_pre_hit: got %b expected 001", bus.hit_rs);
    end
    bus.flush = 3'b001;
    bus.stall = 3'b101;
    present(1'b1, 11'h444, 1'b1, 5'd5);
    step();
    n_checks++;
    if (bus.valid_out !== 3'b110 || bus.hit_rs !== 3'b000 || ctrl_at(0) !== '0 ||
        ctrl_at(1) !== 11'h222 || ctrl_at(2) !== 11'h111) begin
      n_fail++;
      $display("FAIL flush_stall: valid=%b hit_rs=%b s0=%h s1=%h s2=%h expected 110 000 0 222 111",
               bus.valid_out, bus.hit_rs, ctrl_at(0), ctrl_at(1), ctrl_at(2));
    end
    bus.flush = '0;
    bus.stall = '0;
  endtask

  task automatic test_hazard();
    present(1'b1, 11'h101, 1'b1, 5'd3);  step();
    present(1'b1, 11'h102, 1'b0, 5'd3);  step();
    present(1'b1, 11'h103, 1'b1, 5'd3);  step();
    bus.rs = 5'd3;
    bus.rt = 5'd0;
    #1;
    n_checks++;
    if (bus.hit_rs !== 3'b101 || bus.hit_rt !== 3'b000) begin
      n_fail++;
      $display("FAIL hazard_rs3: hit_rs=%b hit_rt=%b expected 101 000", bus.hit_rs, bus.hit_rt);
    end
    bus.rt = 5'd3;
    #1;
    n_checks++;
    if (bus.hit_rt !== 3'b101) begin
      n_fail++;
      $display("FAIL hazard_rt3: hit_rt=%b expected 101", bus.hit_rt);
    end
    for (int i = 0; i < S; i++) begin
      present(1'b1, 11'h104, 1'b1, 5'd0);
      step();
    end
    bus.rs = 5'd0;
    bus.rt = 5'd0;
    #1;
    n_checks++;
    if (bus.hit_rs !== 3'b000 || bus.hit_rt !== 3'b000 || bus.wr_out !== 3'b111) begin
      n_fail++;
      $display("FAIL hazard_r0: hit_rs=%b hit_rt=%b wr=%b expected 000 000 111", bus.hit_rs, bus.hit_rt, bus.wr_out);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < S; i++) begin
      present(1'b1, 11'h1F0, 1'b1, 5'd6);
      step();
    end
    bus.rs = 5'd6;
    #1;
    n_checks++;
    if (bus.hit_rs !== 3'b111) begin
      n_fail++;
      $display("FAIL rstmid_pre: hit_rs=%b expected 111", bus.hit_rs);
    end
    bus.stall = 3'b100;
    rst = 1'b1;
    step();
    n_checks++;
    if (bus.valid_out !== 3'b000 || bus.hit_rs !== 3'b000 || bus.ctrl_out !== '0) begin
      n_fail++;
      $display("FAIL rstmid: valid=%b hit_rs=%b ctrl=%h expected 000 000 0", bus.valid_out, bus.hit_rs, bus.ctrl_out);
    end
    rst = 1'b0;
    bus.stall = '0;
  endtask

  task automatic test_saturation();
    present(1'b0, '0, 1'b0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 5 || i == 15 || i == 20) begin
        int exp_c;
        exp_c = (i < CMAX) ? i : CMAX;
        n_checks++;
        if (bus.bubble_cnt !== C'(exp_c)) begin
          n_fail++;
          $display("FAIL sat_count after %0d: got %0d expected %0d", i, bus.bubble_cnt, exp_c);
        end
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (bus.bubble_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_reset: got %0d expected 0", bus.bubble_cnt);
    end
    step();
    n_checks++;
    if (bus.bubble_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL sat_restart: got %0d expected 1", bus.bubble_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [S-1:0]   ev, ew, ers, ert, st, fl;
      logic [S*W-1:0] ec;
      logic [S*R-1:0] ed;
      for (int k = 0; k < S; k++) begin
        st[k] = ($urandom_range(0, 5) == 0);
        fl[k] = ($urandom_range(0, 7) == 0);
      end
      bus.stall = st;
      bus.flush = fl;
      rst = ($urandom_range(0, 49) == 0);
      present(1'($urandom), W'($urandom), 1'($urandom), R'($urandom_range(0, 7)));
      bus.rs = R'($urandom_range(0, 7));
      bus.rt = R'($urandom_range(0, 7));
      step();
      for (int k = 0; k < S; k++) begin
        ev[k] = m[k].v;
        ew[k] = m[k].v & m[k].w;
        ec[k*W +: W] = m[k].c;
        ed[k*R +: R] = m[k].d;
        ers[k] = m[k].v && m[k].w && (m[k].d == bus.rs) && (bus.rs != 0);
        ert[k] = m[k].v && m[k].w && (m[k].d == bus.rt) && (bus.rt != 0);
      end
      n_checks++;
      if (bus.valid_out !== ev || bus.ctrl_out !== ec || bus.wr_out !== ew || bus.dst_out !== ed) begin
        n_fail++;
        $display("FAIL rand_state %0d: valid=%b ctrl=%h wr=%b dst=%h expected %b %h %b %h",
                 n, bus.valid_out, bus.ctrl_out, bus.wr_out, bus.dst_out, ev, ec, ew, ed);
      end
      n_checks++;
      if (bus.hit_rs !== ers || bus.hit_rt !== ert || bus.hold_out !== (|st) || bus.bubble_cnt !== C'(m_cnt)) begin
        n_fail++;
        $display("FAIL rand_aux %0d: hit_rs=%b hit_rt=%b hold=%b cnt=%0d expected %b %b %b %0d",
                 n, bus.hit_rs, bus.hit_rt, bus.hold_out, bus.bubble_cnt, ers, ert, |st, m_cnt);
      end
    end
    rst = 1'b0;
    bus.stall = '0;
    bus.flush = '0;
  endtask

  initial begin
    for (int k = 0; k < S; k++) m[k] = '0;
    test_reset();
    test_mid_stall();
    test_flush_vs_stall();
    test_hazard();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
